icache_line: RTL and testbench
==============================

# icache_line

Direct-mapped instruction cache with multi-word lines and burst refill, between the CPU fetch port and the memory arbiter. Generalises the single-word icache: configurable sets and words per line, per-line valid bits cleared by a single-cycle flush, and an optional critical-word-first refill. Read-only; no CPU writes.

## Interface
- NUM_SETS, 64, number of lines; power of two, ≥2.
- LINE_WORDS, 4, 32-bit words per line; power of two, 1..16.
- ADDR_WIDTH, 32, byte-address width.
- clk  in  1  clock.
- resetn  in  1  reset: synchronous, active-low.
- flush  in  1  invalidate all lines, abort any access (fence.i / satp change).
- cpu_addr_i  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored; held stable until cpu_ready_o.
- cpu_valid_i  in  1  fetch request.
- cpu_dout_o  out  32  instruction word, valid only while cpu_ready_o.
- cpu_ready_o  out  1  one-cycle completion pulse.
- ram_addr_o  out  ADDR_WIDTH  word-aligned refill address.
- ram_valid_o  out  1  refill word request.
- ram_rdata_i  in  32  refill data, valid with ram_ready_i.
- ram_ready_i  in  1  refill word accepted and returned.

## Operation
- Address split: offset[1:0], word = next log2(LINE_WORDS) bits, idx = next log2(NUM_SETS) bits, tag = remainder.
- Storage: tag array, data array (NUM_SETS·LINE_WORDS × 32), valid vector of NUM_SETS flops.
- States: IDLE, LOOKUP, REFILL, DONE.
- IDLE: on cpu_valid_i latch address into req_addr, issue synchronous array read -> LOOKUP.
- LOOKUP: hit = valid[idx] && tag match. Hit: cpu_ready_o=1, cpu_dout_o = data word -> IDLE. Miss: clear word counter -> REFILL.
- REFILL: ram_valid_o=1, ram_addr_o = {req line base, fill_word, 2'b00}. Each ram_ready_i cycle: write ram_rdata_i into data[idx][fill_word]; if fill_word equals requested word, capture it in crit_q; increment counter. After LINE_WORDS beats: write tag, set valid[idx] -> DONE.
- DONE: cpu_ready_o=1, cpu_dout_o = crit_q -> IDLE.
- Fill order (macro off): word 0 up to LINE_WORDS-1.
- flush: in the same edge clears all valid bits, forces IDLE, drops ram_valid_o next cycle; partially refilled line stays invalid; no cpu_ready_o for the aborted request. If cpu_valid_i is still high the request restarts from IDLE (miss).
- resetn has priority over flush. Reset: state IDLE, all valid 0, req_addr 0, counter 0.
- cpu_valid_i is ignored outside IDLE.

## Timing
- Reset values: cpu_ready_o 0, cpu_dout_o 0, ram_valid_o 0, ram_addr_o 0.
- Hit: cpu_valid_i at cycle T, cpu_ready_o at T+1.
- Miss with zero-wait RAM: ram_valid_o from T+2 for LINE_WORDS cycles; cpu_ready_o at T+2+LINE_WORDS.
- ram_valid_o stays high across beats; ram_addr_o advances the cycle after each ram_ready_i. Memory tolerates ram_valid_o dropping without ready (flush).
- cpu_dout_o is 0 whenever cpu_ready_o is 0.
- Back-to-back: the next request is accepted in the IDLE cycle following cpu_ready_o.

## Configuration
- ICACHE_CWF_EN defined: refill starts at the requested word, wrapping modulo LINE_WORDS within the line (e.g. 2,3,0,1). cpu_ready_o/cpu_dout_o are driven combinationally from ram_rdata_i on the first beat. Remaining beats complete in REFILL. DONE is skipped: after the last beat the FSM returns to IDLE.
- Undefined: linear fill and ready in DONE as above.
- Hit behaviour is identical in both builds.

## Structure
- icache_pkg: state enum, localparams OFFSET_BITS, WORD_BITS, IDX_BITS, TAG_BITS, elaboration checks (power of two, ranges).
- Sub-module icache_data_ram: 1R1W synchronous-read word array; maps to SRAM macros later.
- Tag array, valid vector and FSM stay in icache_line.

## Test plan
- Cold miss at 0x0000_1008, LINE_WORDS=4, zero-wait RAM: beats at 0x1000,0x1004,0x1008,0x100C; ready at T+6 with word at 0x1008 (CWF: order 0x1008,0x100C,0x1000,0x1004; ready at T+2).
- Refetch 0x1000..0x100C after fill -> four hits, each ready one cycle after valid; no ram_valid_o.
- Conflict: 0x1000 then 0x1000+NUM_SETS·16 -> second misses, evicts; 0x1000 misses again.
- Flush on second refill beat -> ram_valid_o low next cycle, no ready; retry misses and refills fully.
- RAM with 3 wait states per beat -> ram_addr_o stable while waiting; data correct.
- Reset mid-refill -> all outputs 0 next cycle; earlier-valid line now misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared constants and helpers for the direct-mapped instruction cache.
// Optional critical-word-first refill is enabled by defining ICACHE_CWF_EN.
package icache_pkg;

    localparam int OFFSET_BITS = 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_REFILL = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic int word_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_bits(input int addr_width, input int num_sets, input int line_words);
        return addr_width - OFFSET_BITS - $clog2(line_words) - $clog2(num_sets);
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// 1R1W word array with registered read; a drop-in spot for an SRAM macro.
module icache_data_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [31:0]   rd_data_o,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [31:0]   wr_data_i
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/icache_line.sv
// Direct-mapped instruction cache with multi-word lines and burst refill.
// Define ICACHE_CWF_EN for critical-word-first refill with early completion.
module icache_line
    import icache_pkg::*;
#(
    parameter int NUM_SETS   = 64,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic                  cpu_valid_i,
    output logic [31:0]           cpu_dout_o,
    output logic                  cpu_ready_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_valid_o,
    input  logic [31:0]           ram_rdata_i,
    input  logic                  ram_ready_i
);

    localparam int WORD_BITS = word_bits(LINE_WORDS);
    localparam int IDX_BITS  = idx_bits(NUM_SETS);
    localparam int TAG_BITS  = tag_bits(ADDR_WIDTH, NUM_SETS, LINE_WORDS);
    localparam int CNT_BITS  = (WORD_BITS > 0) ? WORD_BITS : 1;
    localparam int RAM_AW    = IDX_BITS + WORD_BITS;

    if (!is_pow2(NUM_SETS) || NUM_SETS < 2) begin : g_bad_sets
        $error("icache_line: NUM_SETS must be a power of two >= 2");
    end
    if (!is_pow2(LINE_WORDS) || LINE_WORDS > 16) begin : g_bad_words
        $error("icache_line: LINE_WORDS must be a power of two in 1..16");
    end
    if (TAG_BITS < 1) begin : g_bad_tag
        $error("icache_line: ADDR_WIDTH too small for NUM_SETS and LINE_WORDS");
    end

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [CNT_BITS-1:0]   beat_q, beat_d;
    logic [NUM_SETS-1:0]   valid_q, valid_d;
    logic [TAG_BITS-1:0]   tag_q [NUM_SETS];
    logic                  tag_wr_en;

    logic [IDX_BITS-1:0]   req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [CNT_BITS-1:0]   req_word;
    logic [CNT_BITS-1:0]   fill_word;
    logic                  last_beat;
    logic                  lookup_hit;
    logic [ADDR_WIDTH-1:0] line_base;

    logic                  arr_rd_en;
    logic                  arr_wr_en;
    logic [RAM_AW-1:0]     arr_wr_addr;
    logic [31:0]           arr_rd_data;

    logic                  unused_offset;

`ifndef ICACHE_CWF_EN
    logic [31:0]           crit_q, crit_d;
`endif

    assign req_idx   = req_addr_q[OFFSET_BITS+WORD_BITS +: IDX_BITS];
    assign req_tag   = req_addr_q[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_word  = CNT_BITS'(req_addr_q[OFFSET_BITS +: RAM_AW] & RAM_AW'(LINE_WORDS - 1));
    assign last_beat = (beat_q == CNT_BITS'(LINE_WORDS - 1));
    assign line_base = req_addr_q & ~ADDR_WIDTH'(LINE_WORDS * 4 - 1);
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign unused_offset = ^req_addr_q[OFFSET_BITS-1:0];

`ifdef ICACHE_CWF_EN
    // Counter-width addition wraps the fill position within the line.
    assign fill_word = req_word + beat_q;
`else
    assign fill_word = beat_q;
`endif

    assign arr_wr_addr = (RAM_AW'(req_idx) << WORD_BITS) | RAM_AW'(fill_word);

    icache_data_ram #(
        .DEPTH (NUM_SETS * LINE_WORDS),
        .AW    (RAM_AW)
    ) u_data_ram (
        .clk       (clk),
        .rd_en_i   (arr_rd_en),
        .rd_addr_i (cpu_addr_i[OFFSET_BITS +: RAM_AW]),
        .rd_data_o (arr_rd_data),
        .wr_en_i   (arr_wr_en),
        .wr_addr_i (arr_wr_addr),
        .wr_data_i (ram_rdata_i)
    );

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        beat_d      = beat_q;
        valid_d     = valid_q;
`ifndef ICACHE_CWF_EN
        crit_d      = crit_q;
`endif
        tag_wr_en   = 1'b0;
        arr_rd_en   = 1'b0;
        arr_wr_en   = 1'b0;
        cpu_ready_o = 1'b0;
        cpu_dout_o  = '0;
        ram_valid_o = 1'b0;
        ram_addr_o  = '0;

        case (state_q)
            S_IDLE: begin
                if (cpu_valid_i) begin
                    req_addr_d = cpu_addr_i;
                    arr_rd_en  = 1'b1;
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lookup_hit) begin
                    cpu_ready_o = 1'b1;
                    cpu_dout_o  = arr_rd_data;
                    state_d     = S_IDLE;
                end else begin
                    beat_d  = '0;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                ram_valid_o = 1'b1;
                ram_addr_o  = line_base | (ADDR_WIDTH'(fill_word) << OFFSET_BITS);
                if (ram_ready_i) begin
                    arr_wr_en = 1'b1;
                    beat_d    = beat_q + CNT_BITS'(1);
`ifdef ICACHE_CWF_EN
                    if (beat_q == '0) begin
                        cpu_ready_o = 1'b1;
                        cpu_dout_o  = ram_rdata_i;
                    end
`else
                    if (fill_word == req_word) begin
                        crit_d = ram_rdata_i;
                    end
`endif
                    if (last_beat) begin
                        tag_wr_en        = 1'b1;
                        valid_d[req_idx] = 1'b1;
                        beat_d           = '0;
`ifdef ICACHE_CWF_EN
                        state_d          = S_IDLE;
`else
                        state_d          = S_DONE;
`endif
                    end
                end
            end
            S_DONE: begin
`ifndef ICACHE_CWF_EN
                cpu_ready_o = 1'b1;
                cpu_dout_o  = crit_q;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over everything in flight; the aborted request never completes.
        if (flush) begin
            valid_d     = '0;
            state_d     = S_IDLE;
            tag_wr_en   = 1'b0;
            cpu_ready_o = 1'b0;
            cpu_dout_o  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            req_addr_q <= '0;
            beat_q     <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            beat_q     <= beat_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_wr_en) begin
            tag_q[req_idx] <= req_tag;
        end
`ifndef ICACHE_CWF_EN
        crit_q <= crit_d;
`endif
    end

endmodule

// File: tb/tb_icache_line.sv
// Randomized self-checking bench for icache_line against a line-level cache model.
module tb_icache_line;

    localparam int NS = 64;
    localparam int LW = 4;
    localparam int AW = 32;
    localparam int WB = $clog2(LW);
    localparam int IB = $clog2(NS);
`ifdef ICACHE_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] cpu_addr_i = '0;
    logic          cpu_valid_i = 1'b0;
    logic [31:0]   cpu_dout_o;
    logic          cpu_ready_o;
    logic [AW-1:0] ram_addr_o;
    logic          ram_valid_o;
    logic [31:0]   ram_rdata_i = '0;
    logic          ram_ready_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int wait_states = 0;

    bit            mvalid [NS];
    logic [AW-1:0] mtag   [NS];
    logic [AW-1:0] beats  [$];

    icache_line #(.NUM_SETS(NS), .LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_valid_i (cpu_valid_i),
        .cpu_dout_o  (cpu_dout_o),
        .cpu_ready_o (cpu_ready_o),
        .ram_addr_o  (ram_addr_o),
        .ram_valid_o (ram_valid_o),
        .ram_rdata_i (ram_rdata_i),
        .ram_ready_i (ram_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memw(input logic [AW-1:0] a);
        logic [31:0] w;
        w = 32'(a) & ~32'h3;
        return (w * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
    endfunction

    function automatic int set_of(input logic [AW-1:0] a);
        return int'((a >> (2 + WB)) & AW'(NS - 1));
    endfunction

    function automatic logic [AW-1:0] tag_of(input logic [AW-1:0] a);
        return a >> (2 + WB + IB);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NS; i++) mvalid[i] = 1'b0;
    endtask

    // Memory side: answers each beat after wait_states idle cycles.
    bit            prev_wait = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    int            wcnt = 0;
    always @(posedge clk) begin
        #1;
        if (ram_valid_o) begin
            if (prev_wait) check_eq("ram_addr_stable", ram_addr_o, prev_addr);
            if (wcnt >= wait_states) begin
                ram_ready_i = 1'b1;
                ram_rdata_i = memw(ram_addr_o);
                beats.push_back(ram_addr_o);
                wcnt = 0;
                prev_wait = 1'b0;
            end else begin
                ram_ready_i = 1'b0;
                ram_rdata_i = $urandom;
                wcnt++;
                prev_wait = 1'b1;
            end
            prev_addr = ram_addr_o;
        end else begin
            ram_ready_i = 1'b0;
            wcnt = 0;
            prev_wait = 1'b0;
        end
    end

    task automatic fetch(input logic [AW-1:0] addr);
        bit            exp_hit;
        int            exp_lat;
        int            n;
        bit            got;
        int            s;
        int            w0;
        int            wi;
        logic [AW-1:0] base;
        s = set_of(addr);
        exp_hit = mvalid[s] && (mtag[s] == tag_of(addr));
        exp_lat = exp_hit ? 1 : (CWF ? 2 + wait_states : 2 + LW * (wait_states + 1));
        @(posedge clk); #2;
        beats.delete();
        cpu_addr_i  = addr;
        cpu_valid_i = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(posedge clk); #2;
            n++;
            if (exp_hit) check_eq("hit_no_ram", ram_valid_o, 1'b0);
            if (cpu_ready_o) got = 1'b1;
            else check_eq("dout_zero_idle", cpu_dout_o, 32'h0);
        end
        cpu_valid_i = 1'b0;
        check_eq("ready_seen", got, 1'b1);
        check_eq("latency", 32'(n), 32'(exp_lat));
        check_eq("fetch_data", cpu_dout_o, memw(addr));
        n = 0;
        while (ram_valid_o && n < 400) begin
            @(posedge clk); #2;
            n++;
        end
        check_eq("refill_ended", ram_valid_o, 1'b0);
        if (exp_hit) begin
            check_eq("hit_beats", 32'(beats.size()), 32'h0);
        end else begin
            check_eq("miss_beats", 32'(beats.size()), 32'(LW));
            base = addr & ~AW'(LW * 4 - 1);
            w0 = int'((addr >> 2) & AW'(LW - 1));
            for (int i = 0; i < LW && i < beats.size(); i++) begin
                wi = CWF ? (w0 + i) % LW : i;
                check_eq("beat_addr", beats[i], base + AW'(wi * 4));
            end
            mvalid[s] = 1'b1;
            mtag[s]   = tag_of(addr);
        end
    endtask

    // Starts a miss and returns while the second refill beat is on the bus.
    task automatic start_refill(input logic [AW-1:0] addr);
        int n;
        int seen;
        @(posedge clk); #2;
        beats.delete();
        cpu_addr_i  = addr;
        cpu_valid_i = 1'b1;
        n = 0;
        seen = 0;
        while (seen < 2 && n < 50) begin
            @(posedge clk); #2;
            n++;
            if (ram_valid_o) seen++;
        end
        check_eq("refill_started", 32'(seen), 32'd2);
        cpu_valid_i = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        model_clear();
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_ready", cpu_ready_o, 1'b0);
        check_eq("rst_dout", cpu_dout_o, 32'h0);
        check_eq("rst_ram_valid", ram_valid_o, 1'b0);
        check_eq("rst_ram_addr", ram_addr_o, 32'h0);
        resetn = 1'b1;

        fetch(32'h0000_1008);
        for (int i = 0; i < LW; i++) fetch(32'h0000_1000 + 32'(i * 4));

        fetch(32'h0000_1000 + 32'(NS * LW * 4));
        fetch(32'h0000_1000);

        start_refill(32'h0000_2004);
        flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
        model_clear();
        check_eq("flush_ram_valid", ram_valid_o, 1'b0);
        check_eq("flush_ready", cpu_ready_o, 1'b0);
        repeat (3) begin
            @(posedge clk); #2;
            check_eq("flush_quiet_ready", cpu_ready_o, 1'b0);
            check_eq("flush_quiet_ram", ram_valid_o, 1'b0);
        end
        fetch(32'h0000_2004);
        fetch(32'h0000_1000);

        wait_states = 3;
        fetch(32'h0000_3008);
        fetch(32'h0000_300C);
        wait_states = 0;

        for (int i = 0; i < 40; i++) begin
            a = (AW'($urandom_range(0, 2) * 4 + 1) << (2 + WB + IB))
              | (AW'($urandom_range(0, 2) * 2) << (2 + WB))
              | (AW'($urandom_range(0, LW - 1)) << 2)
              | AW'($urandom_range(0, 3));
            wait_states = $urandom_range(0, 2);
            fetch(a);
        end
        wait_states = 0;

        fetch(32'h0000_1000);
        fetch(32'h0000_1000);
        start_refill(32'h0000_5000);
        resetn = 1'b0;
        @(posedge clk); #2;
        check_eq("midrst_ready", cpu_ready_o, 1'b0);
        check_eq("midrst_dout", cpu_dout_o, 32'h0);
        check_eq("midrst_ram_valid", ram_valid_o, 1'b0);
        check_eq("midrst_ram_addr", ram_addr_o, 32'h0);
        resetn = 1'b1;
        model_clear();
        fetch(32'h0000_1000);
        fetch(32'h0000_1004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
